// File: rtl/cryptoveril_pipe.sv
// cryptoveril_pipe: STAGES-deep XOR/rotate round pipeline, encrypt or decrypt per beat.
// Ports: clk, rst, in_* / out_* valid-ready streams, key_load/key_in/key_err, busy, beat_cnt.
module cryptoveril_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 3,
  parameter int ROT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  output logic              key_err,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] st_m;
  logic [DATA_W-1:0] st_d [STAGES];
  logic [DATA_W-1:0] key;

  function automatic logic [DATA_W-1:0] rotl(
    input logic [DATA_W-1:0] x,
    input int                n
  );
    int s;
    s = n % DATA_W;
    if (s == 0) return x;
    return (x << s) | (x >> (DATA_W - s));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(
    input logic [DATA_W-1:0] x,
    input int                n
  );
    return rotl(x, DATA_W - (n % DATA_W));
  endfunction

  // Decrypt walks the round keys in reverse so that the
  // decrypt pipeline undoes the encrypt pipeline stage by stage.
  function automatic logic [DATA_W-1:0] round_f(
    input logic [DATA_W-1:0] x,
    input logic              m,
    input logic [DATA_W-1:0] k,
    input int                j
  );
    if (!m) return rotl(x ^ rotl(k, j), ROT);
    return rotr(x, ROT) ^ rotl(k, STAGES - 1 - j);
  endfunction

  // Advance chain built with a running variable so the
  // dependence from the output back to stage 0 stays acyclic.
  always_comb begin
    logic a;
    a = out_ready;
    adv = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      a = a || !vld[j];
      adv[j] = a;
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    logic [DATA_W-1:0] src_d;
    logic              src_m;
    logic              src_v;
    logic [DATA_W-1:0] d_q;
    logic              m_q;
    logic              v_q;

    if (j == 0) begin : g_first
      assign src_d = in_data;
      assign src_m = in_mode;
      assign src_v = in_valid;
    end else begin : g_next
      assign src_d = st_d[j-1];
      assign src_m = st_m[j-1];
      assign src_v = vld[j-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        m_q <= 1'b0;
        d_q <= '0;
      end else if (adv[j]) begin
        v_q <= src_v;
        m_q <= src_m;
        d_q <= round_f(src_d, src_m, key, j);
      end
    end

    assign vld[j]  = v_q;
    assign st_m[j] = m_q;
    assign st_d[j] = d_q;
  end

  assign in_ready  = !vld[0] || adv[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = st_d[STAGES-1];
  assign out_mode  = st_m[STAGES-1];
  assign busy      = |vld;

  // Key may only change while no beat is in flight or
  // being offered, so every beat sees one key end to end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key      <= '0;
      key_err  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      key_err <= key_load && (busy || in_valid);
      if (key_load && !busy && !in_valid) key <= key_in;
      if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cryptoveril_pipe.sv
// tb_cryptoveril_pipe: scoreboard bench for cryptoveril_pipe (defaults).
// Tasks per scenario; monitor pops expected beats on each output handshake.
module tb_cryptoveril_pipe;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic         key_load = 1'b0;
  logic [W-1:0] key_in = '0;
  logic         key_err;
  logic         busy;
  logic [15:0]  beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  logic [8:0] obs[$];
  logic [7:0] model_key = 8'h00;
  bit         rand_rdy = 1'b0;
  logic       held_v = 1'b0;
  logic [8:0] held = '0;

  cryptoveril_pipe #(.DATA_W(W), .STAGES(S), .ROT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode),
    .key_load(key_load), .key_in(key_in), .key_err(key_err),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[(b + n) % 8] = x[b];
    return r;
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k);
    logic [7:0] x;
    x = p;
    for (int j = 0; j < S; j++) x = rl(x ^ rl(k, j), 1);
    return x;
  endfunction

  function automatic logic [7:0] dec(input logic [7:0] c, input logic [7:0] k);
    logic [7:0] x;
    x = c;
    for (int j = 0; j < S; j++) x = rl(x, 7) ^ rl(k, S - 1 - j);
    return x;
  endfunction

  // Output monitor: stability while stalled, scoreboard on handshake.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        checks++;
        if ({out_mode, out_data} !== held) begin
          errors++;
          $display("FAIL stall_stable: got %h want %h", {out_mode, out_data}, held);
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_mode, out_data};
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h want none", {out_mode, out_data});
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          if ({out_mode, out_data} !== e) begin
            errors++;
            $display("FAIL beat: got %h want %h", {out_mode, out_data}, e);
          end
        end
        obs.push_back({out_mode, out_data});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic m, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    while (!ok && waits < 200) begin
      @(negedge clk);
      waits++;
      if (in_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
    end else begin
      sb.push_back({m, m ? dec(d, model_key) : enc(d, model_key)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k, input bit expect_ok);
    key_load = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    if (expect_ok) model_key = k;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    model_key = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int w;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b%b want 00", out_valid, busy);
    end
    checks++;
    if (beat_cnt !== 16'h0 || key_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got %h %b want 0000 0", beat_cnt, key_err);
    end
    checks++;
    if (out_data !== 8'h00 || out_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %b want 00 0", out_data, out_mode);
    end
    rst = 1'b0;
    send(8'h01, 1'b0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL first_beat: got %0d waits want 1", w);
    end
    drain();
  endtask

  task automatic test_key_zero();
    int w;
    int n;
    load_key(8'h00, 1'b1);
    send(8'h01, 1'b0, w);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != S) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", n, S);
    end
    checks++;
    if (out_data !== 8'h08 || out_mode !== 1'b0) begin
      errors++;
      $display("FAIL key_zero: got %h %b want 08 0", out_data, out_mode);
    end
    drain();
  endtask

  task automatic test_round_trip();
    int w;
    load_key(8'h5A, 1'b1);
    obs.delete();
    send(8'h00, 1'b0, w);
    send(8'hD2, 1'b1, w);
    drain();
    checks++;
    if (obs.size() != 2) begin
      errors++;
      $display("FAIL rt_count: got %0d want 2", obs.size());
    end else begin
      checks++;
      if (obs[0] !== 9'h0D2) begin
        errors++;
        $display("FAIL rt_enc: got %h want 0d2", obs[0]);
      end
      checks++;
      if (obs[1] !== 9'h100) begin
        errors++;
        $display("FAIL rt_dec: got %h want 100", obs[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    apply_reset();
    load_key(8'h3C, 1'b1);
    obs.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++)
      send(8'($urandom), 1'($urandom_range(0, 1)), w);
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    checks++;
    if (obs.size() != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d want 10", obs.size());
    end
    checks++;
    if (beat_cnt !== 16'd10) begin
      errors++;
      $display("FAIL bp_beat_cnt: got %0d want 10", beat_cnt);
    end
  endtask

  task automatic test_full_stall();
    int w;
    out_ready = 1'b0;
    send(8'h11, 1'b0, w);
    send(8'h22, 1'b1, w);
    send(8'h33, 1'b0, w);
    in_valid = 1'b1;
    in_data = 8'h44;
    in_mode = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: got rdy %b busy %b want 0 1", in_ready, busy);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h44, 1'b1, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL full_swap: got %0d waits want 1", w);
    end
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL still_full: got rdy %b ov %b want 0 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_key_reject();
    int w;
    load_key(8'h5A, 1'b1);
    obs.delete();
    send(8'h00, 1'b0, w);
    key_load = 1'b1;
    key_in = 8'h33;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    @(negedge clk);
    checks++;
    if (key_err !== 1'b1) begin
      errors++;
      $display("FAIL key_err_hi: got %b want 1", key_err);
    end
    @(negedge clk);
    checks++;
    if (key_err !== 1'b0) begin
      errors++;
      $display("FAIL key_err_lo: got %b want 0", key_err);
    end
    drain();
    send(8'h00, 1'b0, w);
    drain();
    checks++;
    if (obs.size() != 2 || obs[0] !== 9'h0D2 || obs[1] !== 9'h0D2) begin
      errors++;
      $display("FAIL key_kept: got %0d beats want 2 x 0d2", obs.size());
    end
  endtask

  task automatic test_reset_midstream();
    int w;
    int cnt;
    out_ready = 1'b0;
    send(8'hA1, 1'b0, w);
    send(8'hB2, 1'b1, w);
    send(8'hC3, 1'b0, w);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got ov %b busy %b want 0 0", out_valid, busy);
    end
    sb.delete();
    model_key = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL rst_no_out: got %0d beats want 0", cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int w;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++)
      send(8'($urandom), 1'($urandom_range(0, 1)), w);
    drain();
    checks++;
    if (beat_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_max: got %h want ffff", beat_cnt);
    end
    send(8'h5E, 1'b0, w);
    drain();
    checks++;
    if (beat_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_wrap: got %h want 0000", beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_key_zero();
    test_round_trip();
    test_backpressure();
    test_full_stall();
    test_key_reject();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
